// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: a 32-step shift-add or restoring
// shift-subtract engine that writes HI/LO and stalls the front end until done.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             ekill,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;

    // eop[0]=0 selects the signed flavour of either operation
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign sign_a = ~eop[0] & ea[WIDTH-1];
    assign sign_b = ~eop[0] & eb[WIDTH-1];
    assign abs_a  = sign_a ? -ea : ea;
    assign abs_b  = sign_b ? -eb : eb;

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod_fix  = neg_res_q ? -acc_q : acc_q;
    assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (ekill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (estart) state_d = S_CALC;
                S_CALC:  if (count_q == LAST) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        if (!reset) begin
            busy  = (state_q != S_IDLE);
            done  = (state_q == S_DONE);
            stall = (state_q == S_IDLE && estart && !ekill) ||
                    (state_q == S_CALC) || (state_q == S_FIX);
        end
    end

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (estart && !ekill) begin
                    count_d   = '0;
                    is_div_d  = eop[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    dz_d      = eop[1] && (eb == '0);
                    if (eop[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end
            end
            S_CALC: begin
                count_d = count_q + 1'b1;
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (!ekill) begin
                    if (is_div_q) begin
                        // divide by zero leaves quotient all ones and remainder = ea
                        hi_d = rem_fix;
                        lo_d = dz_q ? '1 : quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors push expected HI/LO and start
// cycle; a monitor pops and compares on every done pulse.
module tb_ex_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic             clock, reset, estart, ekill;
    logic [1:0]       eop;
    logic [WIDTH-1:0] ea, eb;
    logic             stall, busy, done;
    logic [WIDTH-1:0] hi, lo;

    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .estart(estart),
        .eop   (eop),
        .ea    (ea),
        .eb    (eb),
        .ekill (ekill),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        string            name;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               start;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_latency"}, 64'(cyc - e.start), 64'(LAT));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el, input string name);
        exp_t e;
        int   stall_cnt;
        bit   seen;
        @(negedge clock);
        check({name, "_idle_before"}, 64'(busy), 64'd0);
        e.name = name; e.hi = eh; e.lo = el; e.start = cyc;
        exp_q.push_back(e);
        estart = 1'b1; eop = op; ea = a; eb = b;
        stall_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            else if (stall) stall_cnt++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: got no done within 100 cycles expected done", name);
        end else begin
            check({name, "_done_stall"}, 64'(stall), 64'd0);
            check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(LAT - 1));
        end
        estart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; estart = 1'b1; ekill = 1'b0; eop = 2'b00; ea = '0; eb = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_done",  64'(done),  64'd0);
        check("reset_hi",    64'(hi),    64'd0);
        check("reset_lo",    64'(lo),    64'd0);
        estart = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, "mult_neg5xneg6");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
        run_op(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_neg2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_neg1");
        run_op(2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by_zero_neg");

        // Preload hi/lo = 5/6, then kill a MULT in flight
        run_op(2'b11, 32'd47, 32'd7, 32'd5, 32'd6, "preload_5_6");
        @(negedge clock);
        estart = 1'b1; eop = 2'b00; ea = 32'd3; eb = 32'd4;
        repeat (10) @(negedge clock);
        ekill = 1'b1; estart = 1'b0;
        @(negedge clock);
        ekill = 1'b0;
        check("kill_stall", 64'(stall), 64'd0);
        check("kill_busy",  64'(busy),  64'd0);
        repeat (40) @(negedge clock);
        check("kill_hi", 64'(hi), 64'd5);
        check("kill_lo", 64'(lo), 64'd6);

        // ekill beats estart in IDLE
        estart = 1'b1; ekill = 1'b1;
        #1;
        check("kill_idle_stall", 64'(stall), 64'd0);
        @(negedge clock);
        estart = 1'b0; ekill = 1'b0;
        check("kill_idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of a DIV
        @(negedge clock);
        estart = 1'b1; eop = 2'b10; ea = 32'd1000; eb = 32'd3;
        repeat (20) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("midreset_stall", 64'(stall), 64'd0);
        check("midreset_busy",  64'(busy),  64'd0);
        check("midreset_done",  64'(done),  64'd0);
        check("midreset_hi",    64'(hi),    64'd0);
        check("midreset_lo",    64'(lo),    64'd0);
        @(negedge clock);
        estart = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        run_op(2'b01, 32'd6,          32'd9,      32'd0,  32'd54,  "b2b_multu");
        run_op(2'b11, 32'hDEAD_BEEF,  32'h10000,  32'h0000_BEEF, 32'h0000_DEAD, "b2b_divu");

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
